clk_phase_gen: RTL

//  Parametrised digital clock generator, successor to the single-output PLL wrapper.

---
 rtl/clk_phase_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/clk_phase_gen.sv
// Multi-channel programmable clock divider with per-channel phase offset,
// per-period enable pulses and a lock indicator after a common realignment.
module clk_phase_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
);

  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;

  state_t           state;
  logic [LW-1:0]    lock_cnt;
  logic [DIV_W-1:0] div_q    [NUM_CH];
  logic [DIV_W-1:0] phase_q  [NUM_CH];
  logic [DIV_W-1:0] cnt_q    [NUM_CH];
  logic [DIV_W-1:0] cnt_next [NUM_CH];
  logic [DIV_W-1:0] acc_div;
  logic [DIV_W-1:0] acc_phase;
  logic             cfg_hit;

  always_comb begin
    acc_div   = (cfg_div < TWO) ? TWO : cfg_div;
    acc_phase = (cfg_phase >= acc_div) ? acc_div - ONE : cfg_phase;
    cfg_hit   = cfg_valid && cfg_ready && (state != ALIGN) && (32'(cfg_ch) < NUM_CH);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_next[i] = '0;
      // ALIGN preloads so that a nonzero phase lags the P=0 channels by P cycles
      if (state == ALIGN) begin
        if (phase_q[i] != '0) cnt_next[i] = div_q[i] - phase_q[i];
      end else if (cnt_q[i] < div_q[i] - ONE) begin
        cnt_next[i] = cnt_q[i] + ONE;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= ALIGN;
      lock_cnt  <= '0;
      cfg_ready <= 1'b0;
      locked    <= 1'b0;
      outclk    <= '0;
      outclk_en <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_W'(DEFAULT_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else if (cfg_hit) begin
      div_q[cfg_ch]   <= acc_div;
      phase_q[cfg_ch] <= acc_phase;
      state           <= ALIGN;
      lock_cnt        <= '0;
      cfg_ready       <= 1'b0;
      locked          <= 1'b0;
      outclk          <= '0;
      outclk_en       <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]     <= cnt_next[i];
        outclk[i]    <= (cnt_next[i] < (div_q[i] >> 1));
        outclk_en[i] <= (cnt_next[i] == '0);
      end
      case (state)
        ALIGN: begin
          state     <= SETTLE;
          lock_cnt  <= LW'(1);
          cfg_ready <= 1'b1;
          locked    <= 1'b0;
        end
        SETTLE: begin
          if (lock_cnt == LW'(LOCK_CYCLES)) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: begin
          cfg_ready <= 1'b1;
          locked    <= 1'b1;
        end
      endcase
    end
  end

endmodule
